// File: rtl/pq_pkg.sv
// Shared types for priority-queue devices and the arbiters that front them.
package pq_pkg;

    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int PQ_CAPACITY = 4;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam logic [KEY_WIDTH-1:0] KEY0 = '0;
    localparam logic [VAL_WIDTH-1:0] VAL0 = '0;
    localparam kv_t                  KV0  = '{key: KEY0, val: VAL0};

    typedef enum logic [2:0] {
        ARB   = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/pq_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first pending index after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          valid_o
);

    int idx;

    // Scan from the farthest candidate to the nearest so the nearest pending index wins.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (pending_i[idx[IW-1:0]]) begin
                valid_o = 1'b1;
                grant_o = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin arbiter/sequencer sharing one priority-queue device among N_REQ requesters.
//
// state | meaning
// ARB   | wait for a pending requester while the device is idle; latch winner
// CHECK | reject enq+deq together, enq when full, deq when empty
// ISSUE | one-cycle command strobe; capture head value for a dequeue
// WAIT  | first cycle blanks pq_busy; then wait for busy low or watchdog expiry
// ACK   | one-cycle completion pulse to the granted requester
module pq_arbiter
    import pq_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_enq,
    input  logic [N_REQ-1:0] req_deq,
    input  kv_t  [N_REQ-1:0] req_kvi,
    output logic [N_REQ-1:0] req_ack,
    output logic             req_err,
    output kv_t              req_kvo,
    output logic             pq_enq,
    output logic             pq_deq,
    output kv_t              pq_kvi,
    input  kv_t              pq_kvo,
    input  logic             pq_busy,
    input  logic             pq_full,
    input  logic             pq_empty,
    output logic             hang
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    g_q, g_d;
    logic             op_enq_q, op_enq_d;
    logic             op_deq_q, op_deq_d;
    kv_t              kvi_q, kvi_d;
    kv_t              res_q, res_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hang_q, hang_d;

    logic [N_REQ-1:0] pending;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;

    assign pending = req_enq | req_deq;

    rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
        .pending_i (pending),
        .ptr_i     (rr_q),
        .grant_o   (pick_idx),
        .valid_o   (pick_vld)
    );

    // Next-state and output decode; command outputs are only non-zero in ISSUE, ack only in ACK.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        g_d      = g_q;
        op_enq_d = op_enq_q;
        op_deq_d = op_deq_q;
        kvi_d    = kvi_q;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        hang_d   = hang_q;
        req_ack  = '0;
        req_err  = 1'b0;
        req_kvo  = KV0;
        pq_enq   = 1'b0;
        pq_deq   = 1'b0;
        pq_kvi   = KV0;

        case (state_q)
            ARB: begin
                if (pick_vld && !pq_busy) begin
                    g_d      = pick_idx;
                    op_enq_d = req_enq[pick_idx];
                    op_deq_d = req_deq[pick_idx];
                    kvi_d    = req_kvi[pick_idx];
                    rr_d     = pick_idx;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if ((op_enq_q && op_deq_q) || (op_enq_q && pq_full) || (op_deq_q && pq_empty)) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pq_enq = op_enq_q;
                pq_deq = op_deq_q;
                if (op_enq_q) begin
                    pq_kvi = kvi_q;
                end
                // Head is stable until the dequeue takes effect, so sample it alongside the strobe.
                if (op_deq_q) begin
                    res_d = pq_kvo;
                end
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(TIMEOUT)) begin
                    hang_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Device raises busy only the cycle after the strobe; ignore it on the first WAIT cycle.
                    if ((cnt_q != '0) && !pq_busy) begin
                        err_d   = 1'b0;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                req_ack[g_q] = 1'b1;
                req_err      = err_q;
                if (op_deq_q && !err_q) begin
                    req_kvo = res_q;
                end
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign hang = hang_q;

    // State register with synchronous reset; a reset mid-operation drops the op without an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_q     <= IW'(N_REQ - 1);
            g_q      <= '0;
            op_enq_q <= 1'b0;
            op_deq_q <= 1'b0;
            kvi_q    <= KV0;
            res_q    <= KV0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            hang_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            g_q      <= g_d;
            op_enq_q <= op_enq_d;
            op_deq_q <= op_deq_d;
            kvi_q    <= kvi_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            hang_q   <= hang_d;
        end
    end

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter with a small sorted-array priority-queue device model.
module tb_pq_arbiter;
    import pq_pkg::*;

    localparam int NR = 4;
    localparam int TO = 255;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_enq;
    logic [NR-1:0] req_deq;
    kv_t  [NR-1:0] req_kvi;
    logic [NR-1:0] req_ack;
    logic          req_err;
    kv_t           req_kvo;
    logic          pq_enq;
    logic          pq_deq;
    kv_t           pq_kvi;
    kv_t           pq_kvo;
    logic          pq_busy;
    logic          pq_full;
    logic          pq_empty;
    logic          hang;

    int checks = 0;
    int errors = 0;

    pq_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_enq  (req_enq),
        .req_deq  (req_deq),
        .req_kvi  (req_kvi),
        .req_ack  (req_ack),
        .req_err  (req_err),
        .req_kvo  (req_kvo),
        .pq_enq   (pq_enq),
        .pq_deq   (pq_deq),
        .pq_kvi   (pq_kvi),
        .pq_kvo   (pq_kvo),
        .pq_busy  (pq_busy),
        .pq_full  (pq_full),
        .pq_empty (pq_empty),
        .hang     (hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device model: ascending array, head at index 0, busy for 3 cycles after a strobe.
    kv_t [PQ_CAPACITY-1:0] mem;
    int  cnt;
    int  busy_left;
    bit  stuck;
    bit  hang_mode = 1'b0;

    always @(posedge clk) begin
        kv_t [PQ_CAPACITY-1:0] t;
        int n;
        int i;
        if (!rst_n) begin
            mem       <= '0;
            cnt       <= 0;
            busy_left <= 0;
            stuck     <= 1'b0;
        end else begin
            t = mem;
            n = cnt;
            if (pq_enq && n < PQ_CAPACITY) begin
                i = n;
                while (i > 0 && t[i-1].key > pq_kvi.key) begin
                    t[i] = t[i-1];
                    i--;
                end
                t[i] = pq_kvi;
                n++;
            end
            if (pq_deq && n > 0) begin
                for (int j = 0; j < PQ_CAPACITY - 1; j++) t[j] = t[j+1];
                t[PQ_CAPACITY-1] = KV0;
                n--;
            end
            mem <= t;
            cnt <= n;
            if (pq_enq || pq_deq) begin
                busy_left <= 3;
                if (hang_mode) stuck <= 1'b1;
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
            end
        end
    end

    assign pq_busy  = stuck || (busy_left != 0);
    assign pq_full  = (cnt == PQ_CAPACITY);
    assign pq_empty = (cnt == 0);
    assign pq_kvo   = mem[0];

    int enq_strobes  = 0;
    int deq_strobes  = 0;
    int both_strobes = 0;
    int busy_seen    = 0;

    // Strobe/busy monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (pq_enq) enq_strobes++;
        if (pq_deq) deq_strobes++;
        if (pq_enq && pq_deq) both_strobes++;
        if (pq_busy) busy_seen++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req_enq = '0;
        req_deq = '0;
        req_kvi = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output logic [NR-1:0] ack, output logic err,
                            output kv_t kvo, output bit got);
        got = 1'b0;
        ack = '0;
        err = 1'b0;
        kvo = KV0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                ack = req_ack;
                err = req_err;
                kvo = req_kvo;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req_enq = '0;
        req_deq = '0;
        req_kvi = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ack, req_err, req_kvo, pq_enq, pq_deq, pq_kvi, hang} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b err=%b kvo=%h enq=%b deq=%b kvi=%h hang=%b want all 0",
                     req_ack, req_err, req_kvo, pq_enq, pq_deq, pq_kvi, hang);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_enq_deq();
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        int e0, d0;
        e0 = enq_strobes;
        d0 = deq_strobes;
        req_kvi[0] = '{key: 8'd5, val: 8'h55};
        req_enq[0] = 1'b1;
        wait_ack(50, ack, err, kvo, got);
        req_enq[0] = 1'b0;
        checks++;
        if (!got || ack !== 4'b0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL enq5_ack got=%0d ack=%b err=%b want ack=0001 err=0", got, ack, err);
        end
        req_deq[1] = 1'b1;
        wait_ack(50, ack, err, kvo, got);
        req_deq[1] = 1'b0;
        checks++;
        if (!got || ack !== 4'b0010 || err !== 1'b0) begin
            errors++;
            $display("FAIL deq_ack got=%0d ack=%b err=%b want ack=0010 err=0", got, ack, err);
        end
        checks++;
        if (kvo !== kv_t'{key: 8'd5, val: 8'h55}) begin
            errors++;
            $display("FAIL deq_kvo got %h want 0555", kvo);
        end
        checks++;
        if (pq_empty !== 1'b1 || enq_strobes - e0 != 1 || deq_strobes - d0 != 1) begin
            errors++;
            $display("FAIL enq_deq_device empty=%b enq=%0d deq=%0d want 1 1 1",
                     pq_empty, enq_strobes - e0, deq_strobes - d0);
        end
    endtask

    task automatic test_empty();
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        int d0, b0;
        d0 = deq_strobes;
        b0 = busy_seen;
        req_deq[3] = 1'b1;
        wait_ack(50, ack, err, kvo, got);
        req_deq[3] = 1'b0;
        checks++;
        if (!got || ack !== 4'b1000 || err !== 1'b1) begin
            errors++;
            $display("FAIL empty_reject got=%0d ack=%b err=%b want ack=1000 err=1", got, ack, err);
        end
        checks++;
        if (deq_strobes != d0 || busy_seen != b0) begin
            errors++;
            $display("FAIL empty_no_strobe deq_strobes=%0d busy_cycles=%0d want 0 0",
                     deq_strobes - d0, busy_seen - b0);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        int e0;
        int exp_g;
        do_reset();
        e0 = enq_strobes;
        for (int i = 0; i < NR; i++) req_kvi[i] = '{key: 8'(10 * (i + 1)), val: 8'(i)};
        req_enq = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            exp_g = p % NR;
            wait_ack(60, ack, err, kvo, got);
            req_enq[exp_g] = 1'b0;
            checks++;
            if (!got || ack !== 4'(1 << exp_g) || err !== (p == 4)) begin
                errors++;
                $display("FAIL rr_grant_%0d got=%0d ack=%b err=%b want ack=%b err=%0d",
                         p, got, ack, err, 4'(1 << exp_g), (p == 4));
            end
            if (p == 0) begin
                @(negedge clk);
                req_kvi[0] = '{key: 8'd1, val: 8'hEE};
                req_enq[0] = 1'b1;
            end
        end
        checks++;
        if (enq_strobes - e0 != 4 || pq_full !== 1'b1) begin
            errors++;
            $display("FAIL full_no_strobe enq_strobes=%0d full=%b want 4 1", enq_strobes - e0, pq_full);
        end
    endtask

    task automatic test_ordering();
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        logic [7:0] keys [3];
        logic [7:0] exp_keys [3];
        keys     = '{8'd9, 8'd3, 8'd7};
        exp_keys = '{8'd3, 8'd7, 8'd9};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_kvi[i] = '{key: keys[i], val: 8'hA0 + 8'(i)};
            req_enq[i] = 1'b1;
            wait_ack(50, ack, err, kvo, got);
            req_enq[i] = 1'b0;
            checks++;
            if (!got || ack !== 4'(1 << i) || err !== 1'b0) begin
                errors++;
                $display("FAIL order_enq_%0d got=%0d ack=%b err=%b", i, got, ack, err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            req_deq[3] = 1'b1;
            wait_ack(50, ack, err, kvo, got);
            req_deq[3] = 1'b0;
            checks++;
            if (!got || err !== 1'b0 || kvo.key !== exp_keys[i]) begin
                errors++;
                $display("FAIL order_deq_%0d got=%0d err=%b key=%0d want key=%0d",
                         i, got, err, kvo.key, exp_keys[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_both();
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        int e0, d0;
        e0 = enq_strobes;
        d0 = deq_strobes;
        req_kvi[1] = '{key: 8'd2, val: 8'd2};
        req_enq[1] = 1'b1;
        req_deq[1] = 1'b1;
        wait_ack(50, ack, err, kvo, got);
        req_enq[1] = 1'b0;
        req_deq[1] = 1'b0;
        checks++;
        if (!got || ack !== 4'b0010 || err !== 1'b1 || enq_strobes != e0 || deq_strobes != d0) begin
            errors++;
            $display("FAIL both_reject got=%0d ack=%b err=%b strobes=%0d/%0d want ack=0010 err=1 no strobes",
                     got, ack, err, enq_strobes - e0, deq_strobes - d0);
        end
        checks++;
        if (both_strobes != 0) begin
            errors++;
            $display("FAIL exclusive_strobes saw %0d cycles with enq and deq want 0", both_strobes);
        end
    endtask

    task automatic test_watchdog();
        bit seen;
        int k;
        logic [NR-1:0] ack;
        logic err;
        hang_mode  = 1'b1;
        req_kvi[0] = '{key: 8'd2, val: 8'd0};
        req_enq[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pq_enq) begin
                seen = 1'b1;
                break;
            end
        end
        k   = 0;
        ack = '0;
        err = 1'b0;
        if (seen) begin
            for (int c = 0; c < TO + 20; c++) begin
                @(negedge clk);
                k++;
                if (req_ack != '0) begin
                    ack = req_ack;
                    err = req_err;
                    break;
                end
            end
        end
        req_enq[0] = 1'b0;
        checks++;
        if (!seen || k != TO + 2 || ack !== 4'b0001 || err !== 1'b1 || hang !== 1'b1) begin
            errors++;
            $display("FAIL watchdog strobe=%0d cycles=%0d ack=%b err=%b hang=%b want cycles=%0d ack=0001 err=1 hang=1",
                     seen, k, ack, err, hang, TO + 2);
        end
        @(negedge clk);
        checks++;
        if (hang !== 1'b1) begin
            errors++;
            $display("FAIL hang_sticky got %b want 1", hang);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int acks;
        logic [NR-1:0] ack;
        logic err;
        kv_t kvo;
        bit got;
        do_reset();
        checks++;
        if (hang !== 1'b0) begin
            errors++;
            $display("FAIL hang_cleared got %b want 0", hang);
        end
        req_kvi[1] = '{key: 8'd4, val: 8'd4};
        req_enq[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pq_enq) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {req_ack, req_err, req_kvo, pq_enq, pq_deq, pq_kvi, hang} !== '0) begin
            errors++;
            $display("FAIL reset_mid strobe=%0d ack=%b err=%b kvo=%h enq=%b deq=%b kvi=%h hang=%b want all 0",
                     seen, req_ack, req_err, req_kvo, pq_enq, pq_deq, pq_kvi, hang);
        end
        req_enq[1] = 1'b0;
        hang_mode  = 1'b0;
        rst_n      = 1'b1;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_no_ack saw %0d ack cycles want 0", acks);
        end
        req_deq[2] = 1'b1;
        wait_ack(50, ack, err, kvo, got);
        req_deq[2] = 1'b0;
        checks++;
        if (!got || ack !== 4'b0100 || err !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_arb got=%0d ack=%b err=%b want ack=0100 err=1", got, ack, err);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req_enq = '0;
        req_deq = '0;
        req_kvi = '0;
        test_reset();
        test_enq_deq();
        test_empty();
        test_round_robin();
        test_ordering();
        test_both();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pq_arbiter.md
Name: pq_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one priority-queue device (heap_pq or any pq_if-compatible PQ) among N_REQ requesters.
- Serialises enqueue/dequeue commands and guards against full/empty misuse.
- Issues each command as a single-cycle strobe, tracks the device busy flag, and returns a per-requester completion pulse with result data and error status.
- Sits between client logic and the PQ device; one instance per shared PQ.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, max cycles to wait for pq_busy to fall before flagging a hang.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_enq  in  N_REQ  per-requester enqueue request (level, held until ack)
- req_deq  in  N_REQ  per-requester dequeue request (level, held until ack)
- req_kvi  in  N_REQ x (KEY_WIDTH+VAL_WIDTH)  per-requester kv_t to enqueue
- req_ack  out  N_REQ  one-cycle completion pulse, one-hot
- req_err  out  1  valid with req_ack; 1 = request rejected
- req_kvo  out  KEY_WIDTH+VAL_WIDTH  dequeued kv_t, valid with req_ack on a successful deq
- pq_enq  out  1  device enqueue strobe
- pq_deq  out  1  device dequeue strobe
- pq_kvi  out  KEY_WIDTH+VAL_WIDTH  device input kv_t
- pq_kvo  in  KEY_WIDTH+VAL_WIDTH  device head-of-queue kv_t
- pq_busy  in  1  device busy
- pq_full  in  1  device full
- pq_empty  in  1  device empty
- hang  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ARB, rr_ptr=N_REQ-1.
  - All outputs 0: req_ack, req_err, req_kvo, pq_enq, pq_deq, pq_kvi, hang.
  - Reset mid-operation abandons the op with no ack. The device is reset from the same reset domain.
- A requester is pending when req_enq[i]|req_deq[i].
- ARB state:
  - Wait for any pending requester with pq_busy=0.
  - Winner is the first pending index searched from rr_ptr+1, wrapping modulo N_REQ. Register winner g and its op and kvi.
  - rr_ptr<=g; go to CHECK.
  - Arbitration takes 1 cycle.
- CHECK state:
  - Both enq and deq set: reject.
  - enq with pq_full=1: reject.
  - deq with pq_empty=1: reject.
  - On reject: go to ACK with err=1.
  - Otherwise: go to ISSUE.
- ISSUE state (exactly 1 cycle):
  - enq: drive pq_enq=1, pq_kvi=registered kvi.
  - deq: drive pq_deq=1 and capture pq_kvo into the result register. The head value is valid before the dequeue starts.
  - Clear the watchdog counter; go to WAIT.
- WAIT state:
  - The device raises pq_busy the cycle after the strobe.
  - The first WAIT cycle ignores pq_busy (blanking).
  - On later cycles, pq_busy=0 goes to ACK with err=0.
  - Increment the counter each cycle. Counter reaching TIMEOUT sets hang=1 (sticky until reset) and goes to ACK with err=1.
- ACK state (1 cycle):
  - req_ack[g]=1, req_err=err, req_kvo=result (deq ok), else 0.
  - Go to ARB.
  - The requester drops its request on the ack cycle or the next cycle. The rr_ptr advance prevents immediate re-grant when others are pending.
- Command outputs are 0 outside ISSUE.
- pq_enq and pq_deq are never both 1.
- Only one command is outstanding at any time.
- Minimum turnaround per successful op: ARB+CHECK+ISSUE+(device cycles)+ACK.
- Requests changing while granted are ignored; the registered copy is used.

Decomposition:
- arb_state_t enum (ARB, CHECK, ISSUE, WAIT, ACK) belongs in pq_pkg.
- kv_t, KEY_WIDTH, VAL_WIDTH and KEY0/VAL0 come from pq_pkg.
- One sub-module: rr_pick (combinational round-robin priority encoder; inputs pending vector and rr_ptr; outputs winner index and valid). It is reusable by other PQ arbiters.

Test Plan:
- Enqueue and dequeue:
  - Stimulus: after reset, req 0 enq key 5, then req 1 deq.
  - Required: each ack in order; the deq ack has req_kvo.key=5, req_err=0; pq_empty=1 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold enq simultaneously, each with a distinct key.
  - Required: grants come in order 0,1,2,3. A requester re-asserting after its ack is served after the others.
- Empty reject:
  - Stimulus: deq on an empty PQ.
  - Required: ack with err=1, no pq_deq strobe seen, pq_busy stays 0.
- Full reject:
  - Stimulus: fill the PQ to PQ_CAPACITY, then enq key 1.
  - Required: ack with err=1, no pq_enq strobe seen.
- Ordering and simultaneous request:
  - Stimulus: enq keys 9,3,7 from different requesters, then three deqs.
  - Required: deq results are 3,7,9.
  - Stimulus: a requester asserts enq&deq together.
  - Required: err=1 ack.
- Watchdog and reset:
  - Stimulus: a stub device holds pq_busy=1 forever.
  - Required: hang=1 and err=1 ack after TIMEOUT+1 WAIT cycles.
  - Stimulus: assert rst_n=0 during WAIT.
  - Required: all outputs 0 the next cycle, state ARB, no ack.
